// File: rtl/wb_router.sv
// rtl/wb_router.sv - ALU result write-back router to RegA/RegB strobes and a data-memory req/ack port.
// Optional ack timeout with sticky error: build with WB_ACK_TIMEOUT_EN defined.
module wb_router #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        dest_i,
  output logic              rega_we_o,
  output logic              regb_we_o,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          dest_q;
  logic                timeout;

`ifdef WB_ACK_TIMEOUT_EN
  localparam logic [3:0] TMO = 4'(ACK_TIMEOUT);
  logic [3:0] cnt_q;
  assign timeout = (cnt_q == TMO);
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      busy_o      <= 1'b0;
      rega_we_o   <= 1'b0;
      regb_we_o   <= 1'b0;
      reg_data_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      dest_q      <= '0;
`ifdef WB_ACK_TIMEOUT_EN
      cnt_q       <= '0;
      err_o       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rega_we_o <= 1'b0;
          regb_we_o <= 1'b0;
          if (valid_i && ready_o) begin
            data_q     <= data_i;
            addr_q     <= addr_i;
            dest_q     <= dest_i;
            reg_data_o <= data_i;
            // Outputs are registered, so the ISSUE-cycle values are loaded at the accept edge
            if (dest_i != 3'b000) begin
              state     <= ISSUE;
              ready_o   <= 1'b0;
              busy_o    <= 1'b1;
              rega_we_o <= dest_i[0];
              regb_we_o <= dest_i[1];
              if (dest_i[2]) begin
                mem_req_o   <= 1'b1;
                mem_addr_o  <= addr_i;
                mem_wdata_o <= data_i;
`ifdef WB_ACK_TIMEOUT_EN
                cnt_q       <= 4'd1;
`endif
              end
            end
          end
        end

        ISSUE, WAIT_ACK: begin
          rega_we_o <= 1'b0;
          regb_we_o <= 1'b0;
          if (!mem_req_o || mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
          end else if (timeout) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
`ifdef WB_ACK_TIMEOUT_EN
            err_o     <= 1'b1;
`endif
          end else begin
            state <= WAIT_ACK;
`ifdef WB_ACK_TIMEOUT_EN
            cnt_q <= cnt_q + 4'd1;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          ready_o   <= 1'b1;
          busy_o    <= 1'b0;
          rega_we_o <= 1'b0;
          regb_we_o <= 1'b0;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_router.sv
// tb/tb_wb_router.sv - Directed table-driven bench for wb_router.
// Timeout sequences run only when WB_ACK_TIMEOUT_EN is defined.
module tb_wb_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic [7:0] addr;
  logic [2:0] dest;
  logic       rega_we;
  logic       regb_we;
  logic [7:0] reg_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_router #(.DATA_W(8), .ADDR_W(8), .ACK_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .data_i(data), .addr_i(addr), .dest_i(dest),
    .rega_we_o(rega_we), .regb_we_o(regb_we), .reg_data_o(reg_data),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .busy_o(busy), .err_o(err)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic [7:0]  a;
    logic [2:0]  dst;
    logic        ack;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs [13];

  // {ready, busy, rega, regb, reg_data, req, addr, wdata, err}
  function automatic logic [29:0] mk(input logic r, input logic wa, input logic wb,
                                     input logic [7:0] rd, input logic rq,
                                     input logic [7:0] ad, input logic [7:0] wd,
                                     input logic e);
    return {r, ~r, wa, wb, rd, rq, ad, wd, e};
  endfunction

  function automatic logic [29:0] outs();
    return {ready, busy, rega_we, regb_we, reg_data, mem_req, mem_addr, mem_wdata, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid   = 1'b0;
    data    = 8'h00;
    addr    = 8'h00;
    dest    = 3'b000;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0)};
    vecs[1]  = {1'b1, 8'hA5, 8'h00, 3'b011, 1'b0, mk(0, 1, 1, 8'hA5, 0, 8'h00, 8'h00, 0)};
    vecs[2]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(1, 0, 0, 8'hA5, 0, 8'h00, 8'h00, 0)};
    vecs[3]  = {1'b1, 8'h3C, 8'h10, 3'b100, 1'b0, mk(0, 0, 0, 8'h3C, 1, 8'h10, 8'h3C, 0)};
    vecs[4]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(0, 0, 0, 8'h3C, 1, 8'h10, 8'h3C, 0)};
    vecs[5]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(0, 0, 0, 8'h3C, 1, 8'h10, 8'h3C, 0)};
    vecs[6]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(0, 0, 0, 8'h3C, 1, 8'h10, 8'h3C, 0)};
    vecs[7]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b1, mk(1, 0, 0, 8'h3C, 0, 8'h10, 8'h3C, 0)};
    vecs[8]  = {1'b0, 8'h00, 8'h00, 3'b000, 1'b1, mk(1, 0, 0, 8'h3C, 0, 8'h10, 8'h3C, 0)};
    vecs[9]  = {1'b1, 8'h3C, 8'h00, 3'b000, 1'b0, mk(1, 0, 0, 8'h3C, 0, 8'h10, 8'h3C, 0)};
    vecs[10] = {1'b0, 8'h00, 8'h00, 3'b000, 1'b0, mk(1, 0, 0, 8'h3C, 0, 8'h10, 8'h3C, 0)};
    vecs[11] = {1'b1, 8'h9A, 8'h44, 3'b111, 1'b0, mk(0, 1, 1, 8'h9A, 1, 8'h44, 8'h9A, 0)};
    vecs[12] = {1'b0, 8'h00, 8'h00, 3'b000, 1'b1, mk(1, 0, 0, 8'h9A, 0, 8'h44, 8'h9A, 0)};

    do_reset();
    check("reset_state", {2'b0, outs()}, {2'b0, mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0)});

    for (int i = 0; i < 13; i++) begin
      valid   = vecs[i].v;
      data    = vecs[i].d;
      addr    = vecs[i].a;
      dest    = vecs[i].dst;
      mem_ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), {2'b0, outs()}, {2'b0, vecs[i].exp});
    end
    idle_inputs();

    // valid held while busy: second command waits for IDLE
    valid = 1'b1; data = 8'h11; dest = 3'b001;
    step();
    check("hold_first", {23'b0, rega_we, reg_data}, {23'b0, 1'b1, 8'h11});
    data = 8'h77;
    step();
    check("hold_wait", {30'b0, rega_we, ready}, {30'b0, 1'b0, 1'b1});
    pulses = 0;
    step();
    check("hold_second", {23'b0, rega_we, reg_data}, {23'b0, 1'b1, 8'h77});
    if (rega_we) pulses++;
    valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rega_we) pulses++;
    end
    check("hold_pulses", pulses, 1);

    // reset while waiting for ack
    valid = 1'b1; data = 8'h66; addr = 8'h20; dest = 3'b100;
    step();
    valid = 1'b0;
    step();
    step();
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst", {2'b0, outs()}, {2'b0, mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0)});
    rst = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    check("post_rst_idle", {2'b0, outs()}, {2'b0, mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0)});
    mem_ack = 1'b0;

`ifdef WB_ACK_TIMEOUT_EN
    // ack arriving in the 15th request cycle wins
    valid = 1'b1; data = 8'h5A; addr = 8'h33; dest = 3'b100;
    step();
    valid = 1'b0;
    for (int k = 2; k <= 15; k++) step();
    check("ack15_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("ack15_done", {29'b0, mem_req, ready, err}, {29'b0, 3'b010});

    // no ack: request drops after 15 cycles and err sticks
    valid = 1'b1; data = 8'hC3; addr = 8'h7E; dest = 3'b100;
    step();
    valid = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("tmo_len", n, 15);
    check("tmo_err", {30'b0, err, ready}, {30'b0, 2'b11});
    step();
    step();
    check("tmo_sticky", {31'b0, err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("tmo_rst_clr", {31'b0, err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
